fab_clken_gen: RTL and testbench



---
 rtl/fab_clken_gen.sv | 186 ++++++++++++++++++
 tb/tb_fab_clken_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fab_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : fab_clken_gen
// Purpose  : Fabric clock-enable generator. Derives NCH independent divided
//            enable strobes and square waves from one fabric clock, with
//            run-time divide/bypass reconfiguration applied glitch-free at
//            terminal count, a common phase-align (sync) input and a LOCK flag.
// Revision : 1.0 - initial release
// ============================================================================
module fab_clken_gen #(
  parameter int NCH         = 3,
  parameter int DIV_W       = 5,
  parameter int DIV_INIT    = 3,
  parameter int LOCK_CYCLES = 16,
  localparam int c_sel_w    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               i_fab_clk,
  input  logic               i_reset,
  input  logic               i_cfg_we,
  input  logic [c_sel_w-1:0] i_cfg_sel,
  input  logic [DIV_W-1:0]   i_cfg_div,
  input  logic               i_cfg_bypass,
  output logic               o_cfg_ready,
  input  logic               i_sync,
  output logic [NCH-1:0]     o_clken,
  output logic [NCH-1:0]     o_divclk,
  output logic               o_lock
);

  // Channel count widened by one bit so the select range check never wraps.
  localparam logic [c_sel_w:0] c_nch      = (c_sel_w + 1)'(NCH);
  localparam logic [7:0]       c_lock_lim = 8'(LOCK_CYCLES);
  localparam logic [DIV_W-1:0] c_div_init = DIV_W'(DIV_INIT);

  // Shared pending configuration slot
  logic               r_ready;
  logic               r_pend_vld;
  logic [c_sel_w-1:0] r_pend_sel;
  logic [DIV_W-1:0]   r_pend_div;
  logic               r_pend_byp;

  // Lock settle counter
  logic [7:0]         r_lock_cnt;
  logic               r_lock;

  // Per-channel "safe to reconfigure now" (terminal count or bypass)
  logic [NCH-1:0]     w_tgt_ok;
  logic               w_tgt_rdy;
  logic               w_sel_ok;
  logic               w_accept;
  logic               w_app;
  logic [c_sel_w-1:0] w_app_sel;
  logic [DIV_W-1:0]   w_app_div;
  logic               w_app_byp;
  logic [7:0]         w_lock_nxt;

  assign w_sel_ok   = ({1'b0, i_cfg_sel} < c_nch);
  assign w_accept   = i_cfg_we & r_ready & w_sel_ok;
  assign w_lock_nxt = r_lock_cnt + 8'd1;

  // Pick the safe-point flag of the channel the pending config targets.
  always_comb begin
    w_tgt_rdy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (r_pend_sel == c_sel_w'(i)) begin
        w_tgt_rdy = w_tgt_ok[i];
      end
    end
  end

  // Decide whether a config lands this edge: a pending one at its safe point
  // or on sync, or a fresh write that coincides with sync (applied directly).
  always_comb begin
    w_app     = 1'b0;
    w_app_sel = r_pend_sel;
    w_app_div = r_pend_div;
    w_app_byp = r_pend_byp;
    if (r_pend_vld) begin
      w_app = i_sync | w_tgt_rdy;
    end else if (w_accept & i_sync) begin
      w_app     = 1'b1;
      w_app_sel = i_cfg_sel;
      w_app_div = i_cfg_div;
      w_app_byp = i_cfg_bypass;
    end
  end

  // Pending slot: load on accept, release on apply; ready mirrors emptiness.
  always_ff @(posedge i_fab_clk) begin
    if (i_reset) begin
      r_ready    <= 1'b1;
      r_pend_vld <= 1'b0;
      r_pend_sel <= '0;
      r_pend_div <= '0;
      r_pend_byp <= 1'b0;
    end else if (w_app) begin
      r_ready    <= 1'b1;
      r_pend_vld <= 1'b0;
    end else if (w_accept) begin
      r_ready    <= 1'b0;
      r_pend_vld <= 1'b1;
      r_pend_sel <= i_cfg_sel;
      r_pend_div <= i_cfg_div;
      r_pend_byp <= i_cfg_bypass;
    end
  end

  // Lock counter: cleared by any config activity or sync, then counts up
  // and saturates; LOCK asserts on the edge the count reaches the limit.
  always_ff @(posedge i_fab_clk) begin
    if (i_reset) begin
      r_lock_cnt <= '0;
      r_lock     <= 1'b0;
    end else if (w_accept | r_pend_vld | i_sync) begin
      r_lock_cnt <= '0;
      r_lock     <= 1'b0;
    end else if (r_lock_cnt < c_lock_lim) begin
      r_lock_cnt <= w_lock_nxt;
      r_lock     <= (w_lock_nxt == c_lock_lim);
    end
  end

  assign o_cfg_ready = r_ready;
  assign o_lock      = r_lock;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DIV_W-1:0] r_cnt;
      logic [DIV_W-1:0] r_div;
      logic             r_byp;
      logic             r_clken;
      logic             r_divclk;
      logic             w_hit;

      assign w_tgt_ok[gi] = r_byp | (r_cnt == r_div);
      assign w_hit        = w_app & (w_app_sel == c_sel_w'(gi));

      // Channel divider: apply takes priority, then bypass, sync, counting.
      always_ff @(posedge i_fab_clk) begin
        if (i_reset) begin
          r_cnt    <= '0;
          r_div    <= c_div_init;
          r_byp    <= 1'b0;
          r_clken  <= 1'b0;
          r_divclk <= 1'b0;
        end else if (w_hit) begin
          r_div <= w_app_div;
          r_byp <= w_app_byp;
          r_cnt <= '0;
          if (w_app_byp) begin
            r_clken  <= 1'b1;
            r_divclk <= 1'b0;
          end else if (r_byp | i_sync) begin
            // Restarting from a known phase: no strobe this edge.
            r_clken  <= 1'b0;
            r_divclk <= 1'b0;
          end else begin
            // Applied at terminal count, so this edge is a normal strobe.
            r_clken  <= 1'b1;
            r_divclk <= ~r_divclk;
          end
        end else if (r_byp) begin
          r_cnt    <= '0;
          r_clken  <= 1'b1;
          r_divclk <= 1'b0;
        end else if (i_sync) begin
          r_cnt    <= '0;
          r_clken  <= 1'b0;
          r_divclk <= 1'b0;
        end else if (r_cnt == r_div) begin
          r_cnt    <= '0;
          r_clken  <= 1'b1;
          r_divclk <= ~r_divclk;
        end else begin
          r_cnt    <= r_cnt + 1'b1;
          r_clken  <= 1'b0;
        end
      end

      assign o_clken[gi]  = r_clken;
      assign o_divclk[gi] = r_divclk;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fab_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fab_clken_gen
// Purpose  : Self-checking bench for fab_clken_gen. Each channel is modelled
//            as an anchor edge plus an arithmetic period; strobes fall at
//            anchor + m*(DIV+1), the square wave is the parity of strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fab_clken_gen;
  localparam int NCH   = 3;
  localparam int DIVW  = 5;
  localparam int DINIT = 3;
  localparam int LOCKC = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            we = 1'b0;
  logic [1:0]      sel = '0;
  logic [DIVW-1:0] cdiv = '0;
  logic            cbyp = 1'b0;
  logic            sync = 1'b0;
  logic            ready;
  logic            lock;
  logic [NCH-1:0]  clken;
  logic [NCH-1:0]  divclk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int t = 0;
  int m_a   [NCH];
  bit m_lvl [NCH];
  bit m_as  [NCH];
  int m_div [NCH];
  bit m_byp [NCH];
  bit m_pv, m_pbyp, m_ready;
  int m_psel, m_pdiv, m_le;
  logic [NCH-1:0] e_clken, e_divclk;
  logic e_ready, e_lock;

  fab_clken_gen #(.NCH(NCH), .DIV_W(DIVW), .DIV_INIT(DINIT), .LOCK_CYCLES(LOCKC)) dut (
    .i_fab_clk(clk), .i_reset(rst), .i_cfg_we(we), .i_cfg_sel(sel),
    .i_cfg_div(cdiv), .i_cfg_bypass(cbyp), .o_cfg_ready(ready), .i_sync(sync),
    .o_clken(clken), .o_divclk(divclk), .o_lock(lock)
  );

  always #5 clk = ~clk;

  function automatic bit f_strobe(int c, int tt);
    if (m_byp[c]) return 1'b1;
    if (tt == m_a[c]) return m_as[c];
    if (tt < m_a[c]) return 1'b0;
    return ((tt - m_a[c]) % (m_div[c] + 1)) == 0;
  endfunction

  function automatic bit f_divclk(int c, int tt);
    if (m_byp[c]) return 1'b0;
    return m_lvl[c] ^ (((tt - m_a[c]) / (m_div[c] + 1)) % 2 == 1);
  endfunction

  task automatic m_edge();
    bit acc, app, nb, pvb;
    int tgt, nd;
    t++;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_a[c] = t; m_lvl[c] = 0; m_as[c] = 0; m_div[c] = DINIT; m_byp[c] = 0;
      end
      m_pv = 0; m_ready = 1; m_le = t;
    end else begin
      pvb = m_pv;
      acc = we && m_ready && (int'(sel) < NCH);
      app = 0; tgt = 0; nd = 0; nb = 0;
      if (m_pv) begin
        tgt = m_psel; nd = m_pdiv; nb = m_pbyp;
        app = sync || f_strobe(tgt, t);
      end else if (acc && sync) begin
        app = 1; tgt = int'(sel); nd = int'(cdiv); nb = cbyp;
      end
      for (int c = 0; c < NCH; c++) begin
        if (app && c == tgt) begin
          if (nb) begin
            m_byp[c] = 1; m_div[c] = nd;
          end else if (m_byp[c] || sync) begin
            m_byp[c] = 0; m_div[c] = nd; m_a[c] = t; m_lvl[c] = 0; m_as[c] = 0;
          end else begin
            m_lvl[c] = f_divclk(c, t); m_a[c] = t; m_as[c] = 1; m_div[c] = nd;
          end
        end else if (sync && !m_byp[c]) begin
          m_a[c] = t; m_lvl[c] = 0; m_as[c] = 0;
        end
      end
      if (app) begin
        m_pv = 0; m_ready = 1;
      end else if (acc) begin
        m_pv = 1; m_ready = 0; m_psel = int'(sel); m_pdiv = int'(cdiv); m_pbyp = cbyp;
      end
      if (acc || pvb || sync) m_le = t;
    end
    for (int c = 0; c < NCH; c++) begin
      e_clken[c]  = f_strobe(c, t);
      e_divclk[c] = f_divclk(c, t);
    end
    e_ready = m_ready;
    e_lock  = (t - m_le) >= LOCKC;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
    chk("clken", 32'(clken), 32'(e_clken));
    chk("divclk", 32'(divclk), 32'(e_divclk));
    chk("ready", 32'(ready), 32'(e_ready));
    chk("lock", 32'(lock), 32'(e_lock));
    @(negedge clk);
  endtask

  task automatic cfg(int s, int d, bit b);
    we = 1'b1; sel = 2'(s); cdiv = DIVW'(d); cbyp = b;
    tick();
    we = 1'b0;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 64 && !ready; n++) tick();
    chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and free run from DIV_INIT
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3)  chk("pre_first_strobe", 32'(clken), 32'd0);
      if (k == 4)  chk("first_strobe", 32'(clken), 32'h7);
      if (k == 4)  chk("divclk_rise", 32'(divclk), 32'h7);
      if (k == 8)  chk("divclk_fall", 32'(divclk), 32'h0);
      if (k == 15) chk("lock_before", 32'(lock), 32'd0);
      if (k == 16) chk("lock_after", 32'(lock), 32'd1);
    end

    // ch1 -> DIV=0 mid-count
    tick();
    cfg(1, 0, 1'b0);
    chk("ready_low_after_accept", 32'(ready), 32'd0);
    wait_ready();
    repeat (5) tick();
    chk("ch1_div0_const", 32'(clken[1]), 32'd1);
    repeat (18) tick();

    // ch2 bypass, then leave bypass with DIV=7
    cfg(2, 0, 1'b1);
    wait_ready();
    repeat (3) tick();
    chk("byp_clken", 32'(clken[2]), 32'd1);
    chk("byp_divclk", 32'(divclk[2]), 32'd0);
    cfg(2, 7, 1'b0);
    chk("leave_byp_pending", 32'(ready), 32'd0);
    tick();
    chk("leave_byp_applied", 32'(ready), 32'd1);
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 7) chk("leave_byp_no_strobe", 32'(clken[2]), 32'd0);
      if (j == 8) chk("leave_byp_strobe", 32'(clken[2]), 32'd1);
    end

    // Ignored writes: while pending, and to an out-of-range channel
    cfg(0, 5, 1'b0);
    cfg(0, 1, 1'b0);
    wait_ready();
    cfg(3, 1, 1'b0);
    chk("bad_sel_ignored", 32'(ready), 32'd1);
    repeat (20) tick();

    // Out-of-phase channels, then a one-cycle sync
    cfg(0, 2, 1'b0);
    wait_ready();
    cfg(1, 4, 1'b0);
    wait_ready();
    repeat (2) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_lock_drop", 32'(lock), 32'd0);
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 2) chk("sync_ch0_quiet", 32'(clken[0]), 32'd0);
      if (j == 3) chk("sync_ch0_strobe", 32'(clken[0]), 32'd1);
      if (j == 5) chk("sync_ch1_strobe", 32'(clken[1]), 32'd1);
    end
    repeat (14) tick();

    // Write coinciding with sync: applied immediately
    we = 1'b1; sel = 2'd2; cdiv = 5'd1; cbyp = 1'b0; sync = 1'b1;
    tick();
    we = 1'b0; sync = 1'b0;
    chk("sync_write_ready", 32'(ready), 32'd1);
    repeat (6) tick();

    // Reset while a config is pending
    cfg(0, 20, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_ready", 32'(ready), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 4) chk("reset_div_init", 32'(clken), 32'h7);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      we   = ($urandom % 6) == 0;
      sel  = 2'($urandom % 4);
      cdiv = DIVW'($urandom % 8);
      cbyp = ($urandom % 5) == 0;
      sync = ($urandom % 25) == 0;
      rst  = ($urandom % 250) == 0;
      tick();
    end
    we = 1'b0; sync = 1'b0; rst = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
